// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Segment patterns in gfedcba order, indexed by nibble value.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [3:0] nibble_at(input logic [63:0] word, input int i);
        return 4'(word >> (4 * i));
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: packed hex value in, scanned segment/digit pins out.
// Latency: n/a (wires only).
// Backpressure: none; the display always accepts.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                lzb_en;
    logic [7:0]          seg_out;
    logic [DIGITS-1:0]   digit_en_n;
    logic                frame_start;

    modport master (
        output value, dp, lzb_en,
        input  seg_out, digit_en_n, frame_start
    );

    modport slave (
        input  value, dp, lzb_en,
        output seg_out, digit_en_n, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver_glyph_rom.sv
// Nibble to gfedcba segment lookup.
// Latency: combinational.
// Backpressure: none.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-seg scanner with per-frame snapshot and blanking gaps.
// Latency: outputs registered; snapshot edge is one cycle before frame_start is seen high.
// Backpressure: none; free-running scan.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 256,
    parameter int BLANK  = 16
) (
    input  logic               clk_in,
    input  logic               reset_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [4*DIGITS-1:0] snap_val_q;
    logic [DIGITS-1:0]   snap_dp_q;
    logic                snap_lzb_q;

    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   den_q, den_d;
    logic                fs_q, fs_d;

    logic                take_snap;
    logic [4*DIGITS-1:0] eff_val;
    logic [DIGITS-1:0]   eff_dp;
    logic                eff_lzb;
    logic [DIGITS-1:0]   lzb_mask;
    logic                zero_run;
    logic [3:0]          sel_nibble;
    logic [6:0]          glyph;

    // Outputs are computed from next state, so on the snapshot edge itself the
    // live inputs stand in for the registers being loaded (matters when BLANK=1).
    assign take_snap = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    assign eff_val   = take_snap ? bus.value  : snap_val_q;
    assign eff_dp    = take_snap ? bus.dp     : snap_dp_q;
    assign eff_lzb   = take_snap ? bus.lzb_en : snap_lzb_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        zero_run = 1'b1;
        lzb_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run & (nibble_at(64'(eff_val), i) == 4'h0);
            lzb_mask[i] = zero_run;
        end
    end

    assign sel_nibble = nibble_at(64'(eff_val), int'(idx_d));

    seg7_glyph_rom u_glyph_rom (
        .nibble (sel_nibble),
        .glyph  (glyph)
    );

    always_comb begin
        seg_d = SEG_OFF;
        den_d = '1;
        fs_d  = take_snap;
        if (state_d == ST_SHOW) begin
            den_d[idx_d] = 1'b0;
            seg_d = {eff_dp[idx_d], (eff_lzb && lzb_mask[idx_d]) ? 7'h00 : glyph};
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            cnt_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            snap_lzb_q <= 1'b0;
            seg_q      <= SEG_OFF;
            den_q      <= '1;
            fs_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (take_snap) begin
                snap_val_q <= bus.value;
                snap_dp_q  <= bus.dp;
                snap_lzb_q <= bus.lzb_en;
            end
            seg_q <= seg_d;
            den_q <= den_d;
            fs_q  <= fs_d;
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.digit_en_n  = den_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DWELL=4, BLANK=2 (24-cycle frame).
// Cycle k counts rising edges since reset release; outputs sampled 1 time unit after each edge.
module tb_seg7_scan_driver;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    int   k = 0;

    seg7_scan_driver_if #(.DIGITS(4)) bus_if ();

    seg7_scan_driver #(.DIGITS(4), .DWELL(4), .BLANK(2)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk_in = ~clk_in;

    // Frame layout after edge k: snapshot cycle, then per digit 4 lit + 2 off.
    function automatic int exp_digit(input int kk);
        int p;
        if (kk < 2) return -1;
        p = (kk - 2) % 24;
        return ((p % 6) < 4) ? (p / 6) : -1;
    endfunction

    function automatic bit exp_fs(input int kk);
        return (kk >= 1) && (((kk - 1) % 24) == 0);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        k++;
        #1;
    endtask

    always @(negedge clk_in) begin
        if (reset_n === 1'b1) begin
            compared++;
            assert ($countones(~bus_if.digit_en_n) <= 1)
            else begin
                $display("FAIL onehot_en t=%0t got digit_en_n=%h want at most one low", $time, bus_if.digit_en_n);
                mismatched++;
            end
            if (bus_if.digit_en_n === 4'hF) begin
                compared++;
                if (bus_if.seg_out !== 8'h00) begin
                    $display("FAIL dark_seg t=%0t got seg=%h want 00", $time, bus_if.seg_out);
                    mismatched++;
                end
            end
        end
    end

    task automatic test_reset();
        bus_if.value  = 16'h12AF;
        bus_if.dp     = 4'b0000;
        bus_if.lzb_en = 1'b0;
        #12;
        compared++;
        if (bus_if.seg_out !== 8'h00) begin
            $display("FAIL reset_seg got %h want 00", bus_if.seg_out); mismatched++;
        end
        compared++;
        if (bus_if.digit_en_n !== 4'hF) begin
            $display("FAIL reset_den got %h want f", bus_if.digit_en_n); mismatched++;
        end
        compared++;
        if (bus_if.frame_start !== 1'b0) begin
            $display("FAIL reset_fs got %b want 0", bus_if.frame_start); mismatched++;
        end
    endtask

    task automatic test_scan();
        logic [7:0] g [4];
        logic [3:0] eden;
        logic [7:0] eseg;
        int d;
        g = '{8'h71, 8'h77, 8'h5B, 8'h06};
        @(negedge clk_in);
        reset_n = 1'b1;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            d    = exp_digit(k);
            eden = (d < 0) ? 4'hF : 4'(~(4'b0001 << d));
            eseg = (d < 0) ? 8'h00 : g[d];
            compared++;
            if (bus_if.digit_en_n !== eden) begin
                $display("FAIL scan_den k=%0d got %h want %h", k, bus_if.digit_en_n, eden); mismatched++;
            end
            compared++;
            if (bus_if.seg_out !== eseg) begin
                $display("FAIL scan_seg k=%0d got %h want %h", k, bus_if.seg_out, eseg); mismatched++;
            end
            compared++;
            if (bus_if.frame_start !== exp_fs(k)) begin
                $display("FAIL scan_fs k=%0d got %b want %b", k, bus_if.frame_start, exp_fs(k)); mismatched++;
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [7:0] g_old [4];
        logic [3:0] eden;
        logic [7:0] eseg;
        int d;
        g_old = '{8'h71, 8'h77, 8'h5B, 8'h06};
        for (int c = 0; c < 48; c++) begin
            tick();
            if (k == 33) bus_if.value = 16'h0000;
            d    = exp_digit(k);
            eden = (d < 0) ? 4'hF : 4'(~(4'b0001 << d));
            eseg = (d < 0) ? 8'h00 : ((k <= 48) ? g_old[d] : 8'h3F);
            compared++;
            if (bus_if.digit_en_n !== eden) begin
                $display("FAIL mid_den k=%0d got %h want %h", k, bus_if.digit_en_n, eden); mismatched++;
            end
            compared++;
            if (bus_if.seg_out !== eseg) begin
                $display("FAIL mid_seg k=%0d got %h want %h", k, bus_if.seg_out, eseg); mismatched++;
            end
            compared++;
            if (bus_if.frame_start !== exp_fs(k)) begin
                $display("FAIL mid_fs k=%0d got %b want %b", k, bus_if.frame_start, exp_fs(k)); mismatched++;
            end
        end
    endtask

    task automatic test_lzb();
        logic [7:0] g [4];
        logic [3:0] eden;
        logic [7:0] eseg;
        int d;
        g = '{8'h3F, 8'h07, 8'h00, 8'h80};
        bus_if.value  = 16'h0070;
        bus_if.dp     = 4'b1000;
        bus_if.lzb_en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            d    = exp_digit(k);
            eden = (d < 0) ? 4'hF : 4'(~(4'b0001 << d));
            eseg = (d < 0) ? 8'h00 : g[d];
            compared++;
            if (bus_if.digit_en_n !== eden) begin
                $display("FAIL lzb_den k=%0d got %h want %h", k, bus_if.digit_en_n, eden); mismatched++;
            end
            compared++;
            if (bus_if.seg_out !== eseg) begin
                $display("FAIL lzb_seg k=%0d got %h want %h", k, bus_if.seg_out, eseg); mismatched++;
            end
        end
    endtask

    task automatic test_lzb_all_zero();
        logic [7:0] g [4];
        logic [3:0] eden;
        logic [7:0] eseg;
        int d;
        g = '{8'h3F, 8'h00, 8'h00, 8'h00};
        bus_if.value  = 16'h0000;
        bus_if.dp     = 4'b0000;
        bus_if.lzb_en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            d    = exp_digit(k);
            eden = (d < 0) ? 4'hF : 4'(~(4'b0001 << d));
            eseg = (d < 0) ? 8'h00 : g[d];
            compared++;
            if (bus_if.digit_en_n !== eden) begin
                $display("FAIL lzb0_den k=%0d got %h want %h", k, bus_if.digit_en_n, eden); mismatched++;
            end
            compared++;
            if (bus_if.seg_out !== eseg) begin
                $display("FAIL lzb0_seg k=%0d got %h want %h", k, bus_if.seg_out, eseg); mismatched++;
            end
        end
    endtask

    task automatic test_reset_mid_show();
        logic [3:0] eden;
        logic [7:0] eseg;
        int d;
        bus_if.value  = 16'h12AF;
        bus_if.dp     = 4'b0000;
        bus_if.lzb_en = 1'b0;
        while (k < 135) tick();
        compared++;
        if (bus_if.digit_en_n !== 4'b1011 || bus_if.seg_out !== 8'h5B) begin
            $display("FAIL pre_reset k=%0d got den=%h seg=%h want den=b seg=5b", k, bus_if.digit_en_n, bus_if.seg_out);
            mismatched++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if (bus_if.seg_out !== 8'h00) begin
            $display("FAIL async_rst_seg got %h want 00", bus_if.seg_out); mismatched++;
        end
        compared++;
        if (bus_if.digit_en_n !== 4'hF) begin
            $display("FAIL async_rst_den got %h want f", bus_if.digit_en_n); mismatched++;
        end
        compared++;
        if (bus_if.frame_start !== 1'b0) begin
            $display("FAIL async_rst_fs got %b want 0", bus_if.frame_start); mismatched++;
        end
        @(posedge clk_in);
        #1;
        compared++;
        if (bus_if.digit_en_n !== 4'hF) begin
            $display("FAIL held_rst_den got %h want f", bus_if.digit_en_n); mismatched++;
        end
        @(negedge clk_in);
        reset_n = 1'b1;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            d    = exp_digit(k);
            eden = (d < 0) ? 4'hF : 4'(~(4'b0001 << d));
            eseg = (d < 0) ? 8'h00 : 8'h71;
            compared++;
            if (bus_if.digit_en_n !== eden) begin
                $display("FAIL restart_den k=%0d got %h want %h", k, bus_if.digit_en_n, eden); mismatched++;
            end
            compared++;
            if (bus_if.seg_out !== eseg) begin
                $display("FAIL restart_seg k=%0d got %h want %h", k, bus_if.seg_out, eseg); mismatched++;
            end
            compared++;
            if (bus_if.frame_start !== exp_fs(k)) begin
                $display("FAIL restart_fs k=%0d got %b want %b", k, bus_if.frame_start, exp_fs(k)); mismatched++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_midframe_change();
        test_lzb();
        test_lzb_all_zero();
        test_reset_mid_show();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
